// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed MULT/DIV sequencer driving the HI/LO registers.
// Works on operand magnitudes (shift-add multiply, restoring divide) and
// applies sign correction in a final FIX cycle. A divide by zero skips the
// iterations and only pulses done/div_zero, leaving HI/LO untouched.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX, ZERO} state_t;

    state_t             state, nextState;
    logic               opDiv, signA, signB;
    logic [WIDTH-1:0]   magA, magB;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      count;
    logic               lastIter;

    // Multiply step: conditional add into the upper half (one carry bit), then shift right
    logic [WIDTH:0]     mulSum;
    logic [2*WIDTH-1:0] mulNext;
    // Divide step: shift remainder:quotient left, trial-subtract the divisor
    logic [WIDTH:0]     divShift, divDiff;
    logic [2*WIDTH-1:0] divNext;
    // Sign-corrected results presented at FIX
    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0]   quoFix, remFix;

    function automatic logic [WIDTH-1:0] absVal(input logic [WIDTH-1:0] v);
        // Most negative value maps to 2^(WIDTH-1), which still fits as unsigned
        return v[WIDTH-1] ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] negIf(input logic neg, input logic [WIDTH-1:0] v);
        return neg ? -v : v;
    endfunction

    assign lastIter = (count == CW'(WIDTH - 1));
    assign busy     = (state != IDLE);

    assign mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, magA};
    assign mulNext  = acc[0] ? {mulSum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

    assign divShift = acc[2*WIDTH-1:WIDTH-1];
    assign divDiff  = divShift - {1'b0, magB};
    assign divNext  = divDiff[WIDTH] ? {divShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                     : {divDiff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

    assign prodFix  = (signA ^ signB) ? -acc : acc;
    assign quoFix   = negIf(signA ^ signB, acc[WIDTH-1:0]);
    assign remFix   = negIf(signA, acc[2*WIDTH-1:WIDTH]);

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    // Next-state logic: divide by zero short-circuits through ZERO
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = (op_div && (src_b == '0)) ? ZERO : RUN;
            RUN:     if (lastIter) nextState = FIX;
            FIX:     nextState = IDLE;
            ZERO:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Operand capture, iteration datapath, result write and status pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opDiv    <= 1'b0;
            signA    <= 1'b0;
            signB    <= 1'b0;
            magA     <= '0;
            magB     <= '0;
            acc      <= '0;
            count    <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        opDiv <= op_div;
                        signA <= src_a[WIDTH-1];
                        signB <= src_b[WIDTH-1];
                        magA  <= absVal(src_a);
                        magB  <= absVal(src_b);
                        count <= '0;
                        // Lower half seeds the multiplier or the dividend
                        acc   <= op_div ? {{WIDTH{1'b0}}, absVal(src_a)}
                                        : {{WIDTH{1'b0}}, absVal(src_b)};
                    end
                end
                RUN: begin
                    acc   <= opDiv ? divNext : mulNext;
                    count <= count + CW'(1);
                end
                FIX: begin
                    if (opDiv) begin
                        hi_out <= remFix;
                        lo_out <= quoFix;
                    end else begin
                        hi_out <= prodFix[2*WIDTH-1:WIDTH];
                        lo_out <= prodFix[WIDTH-1:0];
                    end
                    done <= 1'b1;
                end
                ZERO: begin
                    done     <= 1'b1;
                    div_zero <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with a scoreboard of expected HI/LO results.
module tb_muldiv_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         op_div = 1'b0;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi_out, lo_out;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op_div(op_div),
        .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
        .div_zero(div_zero), .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        string        tag;
    } exp_t;

    exp_t         sbq[$];
    exp_t         mExp;
    logic [W-1:0] heldHi = '0;
    logic [W-1:0] heldLo = '0;
    int           tests = 0;
    int           fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model using native signed arithmetic (truncating division)
    task automatic pushExpect(input bit d, input logic [W-1:0] a, input logic [W-1:0] b,
                              input string tag);
        exp_t   e;
        longint sa, sb, q, r, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.tag = tag;
        e.dz  = 1'b0;
        if (d && b == '0) begin
            e.hi = heldHi;
            e.lo = heldLo;
            e.dz = 1'b1;
        end else if (d) begin
            q = sa / sb;
            r = sa % sb;
            e.hi = r[W-1:0];
            e.lo = q[W-1:0];
        end else begin
            p = sa * sb;
            e.hi = p[63:32];
            e.lo = p[31:0];
        end
        heldHi = e.hi;
        heldLo = e.lo;
        sbq.push_back(e);
    endtask

    // Called at a falling edge; start is sampled at the next rising edge
    task automatic startOp(input bit d, input logic [W-1:0] a, input logic [W-1:0] b,
                           input string tag);
        op_div = d;
        src_a  = a;
        src_b  = b;
        start  = 1'b1;
        pushExpect(d, a, b, tag);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_on"}, busy, 1);
    endtask

    task automatic waitDone(input int n0, input int expLat, input string tag);
        int n;
        n = n0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, expLat);
        check({tag, "_busy_off"}, busy, 0);
    endtask

    // Scoreboard: every done pulse retires the oldest expected result
    always @(negedge clk) begin
        if (reset && done) begin
            if (sbq.size() == 0) begin
                check("spurious_done", done, 0);
            end else begin
                mExp = sbq.pop_front();
                check({mExp.tag, "_hi"}, hi_out, mExp.hi);
                check({mExp.tag, "_lo"}, lo_out, mExp.lo);
                check({mExp.tag, "_divzero"}, div_zero, mExp.dz);
            end
        end
        if (reset && div_zero && !done) check("divzero_without_done", div_zero, 0);
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int dc;
        bit d;
        logic [W-1:0] a, b;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_divzero", div_zero, 0);
        check("rst_hi", hi_out, 0);
        check("rst_lo", lo_out, 0);
        reset = 1'b1;
        @(negedge clk);

        // Signed multiply with mixed signs
        startOp(0, 32'd7, 32'hFFFF_FFFD, "mul7xm3");
        waitDone(0, 33, "mul7xm3");
        check("mul7xm3_hi_const", hi_out, 32'hFFFF_FFFF);
        check("mul7xm3_lo_const", lo_out, 32'hFFFF_FFEB);

        // Signed divide, truncation toward zero, started in the done cycle
        startOp(1, 32'hFFFF_FFF9, 32'd2, "divm7by2");
        waitDone(0, 33, "divm7by2");
        check("divm7by2_lo_const", lo_out, 32'hFFFF_FFFD);
        check("divm7by2_hi_const", hi_out, 32'hFFFF_FFFF);

        // Preload then divide by zero: HI/LO keep 0/12
        startOp(0, 32'd3, 32'd4, "mul3x4");
        waitDone(0, 33, "mul3x4");
        startOp(1, 32'd100, 32'd0, "div100by0");
        waitDone(0, 1, "div100by0");

        // Start in the done cycle; previous result holds until the new FIX
        startOp(0, 32'h8000_0000, 32'h8000_0000, "mulmin");
        repeat (10) @(negedge clk);
        check("hold_lo_during_run", lo_out, 32'd12);
        check("hold_hi_during_run", hi_out, 32'd0);
        waitDone(10, 33, "mulmin");
        check("mulmin_hi_const", hi_out, 32'h4000_0000);

        startOp(1, 32'h8000_0000, 32'hFFFF_FFFF, "divminbym1");
        waitDone(0, 33, "divminbym1");

        // Re-pulsed start with altered operands while busy is ignored
        startOp(0, 32'd12345, 32'hFFFF_FD5A, "mulrepulse");
        repeat (4) @(negedge clk);
        start = 1'b1; op_div = 1'b1; src_a = 32'd999; src_b = 32'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        start = 1'b1; src_a = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        waitDone(20, 33, "mulrepulse");

        // A few random operations
        for (int i = 0; i < 4; i++) begin
            d = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            if (d && b == '0) b = 32'd1;
            startOp(d, a, b, $sformatf("rand%0d", i));
            waitDone(0, 33, $sformatf("rand%0d", i));
        end

        // Reset mid-divide aborts without a done pulse
        @(negedge clk);
        startOp(1, 32'd1000, 32'd7, "rstdiv");
        repeat (14) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_hi", hi_out, 0);
        check("midrst_lo", lo_out, 0);
        sbq.delete();
        heldHi = '0;
        heldLo = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        dc = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dc++;
        end
        check("midrst_no_done", dc, 0);
        check("midrst_busy_after", busy, 0);

        check("scoreboard_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle controller for the MULT/DIV resource feeding the HI/LO registers in the multicycle CPU.
- Accepts a start command from the main control FSM and captures operands from the DivSrcA/DivSrcB mux outputs.
- Runs a 32-iteration shift-add multiply or a restoring divide.
- Drives busy so the control FSM can stall, and pulses done when HI/LO are updated.
- Flags divide-by-zero so control can raise the exception/EPC path.

Parameters:
WIDTH, 32, operand width; iteration count equals WIDTH.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  command request; sampled only when the block is idle.
op_div  input  1  0 = signed MULT, 1 = signed DIV; sampled with start.
src_a  input  WIDTH  multiplicand / dividend (DivSrcA_out).
src_b  input  WIDTH  multiplier / divisor (DivSrcB_out).
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse; HI/LO are valid in this cycle.
div_zero  output  1  one-cycle pulse, coincident with done, on a divide by zero.
hi_out  output  WIDTH  HI register: product upper half / remainder.
lo_out  output  WIDTH  LO register: product lower half / quotient.

Behaviour:
Reset
- reset low, asynchronous: state = IDLE.
- busy, done, div_zero = 0; hi_out, lo_out = 0; all internal accumulators and counter cleared.
- Reset during RUN or FIX aborts the operation; no done pulse.

State machine
- States: IDLE, RUN, FIX, ZERO.
- IDLE + start=1 at edge E0:
  - capture op_div, |src_a|, |src_b| and both sign bits.
  - counter = 0; busy = 1 after E0.
  - Next state is ZERO if op_div=1 and src_b=0, else RUN.
- RUN: one iteration per edge.
  - MULT: if multiplier LSB is set, add multiplicand to the upper half of the 2*WIDTH accumulator; then shift right by 1.
  - DIV: shift remainder:quotient left by 1; trial subtract divisor; on no borrow, keep the difference and set quotient LSB.
  - After the WIDTH-th iteration (edge E32), go to FIX.
- FIX, one edge (E33): apply sign correction and write the results.
  - MULT: negate the 64-bit product if the operand signs differ. hi_out = upper word, lo_out = lower word.
  - DIV: negate the quotient if the signs differ; negate the remainder if the dividend was negative. lo_out = quotient, hi_out = remainder.
  - After E33: done = 1, busy = 0, state = IDLE.
- ZERO, one edge (E1): hi_out/lo_out unchanged; done = 1 and div_zero = 1 for one cycle; busy = 0; state = IDLE.

Timing
- Latency start-edge to done-cycle: 33 cycles (MULT/DIV), 1 cycle (divide by zero).
- done and div_zero are high for exactly one cycle.

Handshake and boundaries
- start while busy=1 is ignored. Operand/op changes during busy are ignored (captured copies are used).
- start is accepted in the same cycle done is high, since the state is IDLE. A new op then begins and hi_out/lo_out hold the completed result until its FIX.
- hi_out/lo_out change only at a FIX edge or at reset.
- Division truncates toward zero. Dividend 0x80000000 / divisor 0xFFFFFFFF gives lo_out = 0x80000000, hi_out = 0; no flag is raised.
- Multiplication with 0x80000000 operands uses the magnitude 2^31 correctly (accumulator is WIDTH+1 bits wide on add).

Test Plan:
- MULT 7 x 0xFFFFFFFD (-3): start at edge 0 -> busy high for 33 cycles; done at cycle 33; hi_out = 0xFFFFFFFF, lo_out = 0xFFFFFFEB.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo_out = 0xFFFFFFFD, hi_out = 0xFFFFFFFF, div_zero = 0, latency 33.
- DIV 100 / 0 -> done and div_zero both high in cycle 1; hi_out/lo_out keep their prior values (preload via MULT 3 x 4 -> lo_out = 12, hi_out = 0 unchanged).
- DIV 0x80000000 / 0xFFFFFFFF -> lo_out = 0x80000000, hi_out = 0. MULT 0x80000000 x 0x80000000 -> hi_out = 0x40000000, lo_out = 0.
- start re-pulsed at cycles 5 and 20 of a MULT with altered src_a -> ignored; result matches the original operands. start in the done cycle -> second op accepted, done 33 cycles later.
- reset low at cycle 15 of a DIV -> busy, done, hi_out, lo_out = 0 immediately; no done pulse after reset release.
